// File: rtl/video_timing_pkg.sv
// Video raster timing: shared types and constants.
// Horizontal defaults plus per-mode vertical timing tables.
package video_timing_pkg;

  typedef struct packed {
    logic [8:0] active;
    logic [8:0] fp;
    logic [8:0] sync;
    logic [8:0] bp;
    logic [8:0] total;
  } vtiming_t;

  localparam int H_ACTIVE_D = 320;
  localparam int H_FP_D     = 14;
  localparam int H_SYNC_D   = 32;
  localparam int H_BP_D     = 60;
  localparam int H_TOTAL    =
    H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;

  localparam vtiming_t V_NTSC = '{
    active: 9'd240, fp: 9'd3, sync: 9'd3,
    bp: 9'd16, total: 9'd262
  };

  localparam vtiming_t V_PAL = '{
    active: 9'd288, fp: 9'd3, sync: 9'd3,
    bp: 9'd18, total: 9'd312
  };

  function automatic vtiming_t vtiming(
    input logic pal
  );
    return pal ? V_PAL : V_NTSC;
  endfunction

  function automatic logic [8:0] vtotal(
    input logic pal
  );
    vtiming_t t;
    t = vtiming(pal);
    return t.total;
  endfunction

  function automatic logic [8:0] vactive(
    input logic pal
  );
    vtiming_t t;
    t = vtiming(pal);
    return t.active;
  endfunction

  function automatic logic [8:0] vsync_start(
    input logic pal
  );
    vtiming_t t;
    t = vtiming(pal);
    return t.active + t.fp;
  endfunction

  function automatic logic [8:0] vsync_end(
    input logic pal
  );
    vtiming_t t;
    t = vtiming(pal);
    return t.active + t.fp + t.sync;
  endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// One raster axis: wrapping counter with blank/sync decode.
// wrap is combinational so the next axis steps on the same edge.
module timing_axis (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic [8:0] total,
  input  logic [8:0] active,
  input  logic [8:0] sync_start,
  input  logic [8:0] sync_end,
  output logic [8:0] count,
  output logic       blank,
  output logic       sync,
  output logic       wrap
);

  logic [8:0] nxt;

  // >= also pulls an out-of-range count back to zero
  assign wrap = advance && (count >= total - 9'd1);

  // next count, so decodes match the presented value
  always_comb begin
    nxt = count;
    if (advance)
      nxt = wrap ? 9'd0 : count + 9'd1;
  end

  // counter and decoded outputs step together
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 9'd0;
      blank <= 1'b0;
      sync  <= 1'b0;
    end else if (advance) begin
      count <= nxt;
      blank <= nxt >= active;
      sync  <= (nxt >= sync_start) &&
               (nxt < sync_end);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator for 240p/288p.
// Mode is latched only at frame wrap, so frames never tear.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CE_DIV   = 4,
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_pal,
  output logic       ce_pix,
  output logic [8:0] hcount,
  output logic [8:0] vcount,
  output logic       h_blank,
  output logic       v_blank,
  output logic       h_sync,
  output logic       v_sync,
  output logic       line_start,
  output logic       frame_start,
  output logic       mode_active
);

  localparam int H_TOT =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int DW = $clog2(CE_DIV);

  logic [DW-1:0] div;
  logic          adv;
  logic          h_wrap;
  logic          v_wrap;

  assign adv = (div == DW'(CE_DIV - 1));

  // pixel divider; ce_pix rises with the counter step
  always_ff @(posedge clk) begin
    if (reset) begin
      div    <= '0;
      ce_pix <= 1'b0;
    end else begin
      div    <= adv ? '0 : div + DW'(1);
      ce_pix <= adv;
    end
  end

  timing_axis u_h (
    .clk        (clk),
    .reset      (reset),
    .advance    (adv),
    .total      (9'(H_TOT)),
    .active     (9'(H_ACTIVE)),
    .sync_start (9'(H_ACTIVE + H_FP)),
    .sync_end   (9'(H_ACTIVE + H_FP + H_SYNC)),
    .count      (hcount),
    .blank      (h_blank),
    .sync       (h_sync),
    .wrap       (h_wrap)
  );

  timing_axis u_v (
    .clk        (clk),
    .reset      (reset),
    .advance    (h_wrap),
    .total      (vtotal(mode_active)),
    .active     (vactive(mode_active)),
    .sync_start (vsync_start(mode_active)),
    .sync_end   (vsync_end(mode_active)),
    .count      (vcount),
    .blank      (v_blank),
    .sync       (v_sync),
    .wrap       (v_wrap)
  );

  // strobes and the mode latch, all on the wrap edge
  always_ff @(posedge clk) begin
    if (reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      mode_active <= mode_pal;
    end else begin
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      if (v_wrap)
        mode_active <= mode_pal;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with a reduced line length.
// Reference tracks a linear pixel index within the frame.
module tb_video_timing_gen;

  localparam int CE  = 4;
  localparam int HA  = 8;
  localparam int HFP = 2;
  localparam int HSY = 3;
  localparam int HBP = 3;
  localparam int HT  = HA + HFP + HSY + HBP;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode_pal = 1'b0;
  logic       ce_pix;
  logic [8:0] hcount;
  logic [8:0] vcount;
  logic       h_blank;
  logic       v_blank;
  logic       h_sync;
  logic       v_sync;
  logic       line_start;
  logic       frame_start;
  logic       mode_active;

  always #5 clk = ~clk;

  video_timing_gen #(
    .CE_DIV   (CE),
    .H_ACTIVE (HA),
    .H_FP     (HFP),
    .H_SYNC   (HSY),
    .H_BP     (HBP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode_pal    (mode_pal),
    .ce_pix      (ce_pix),
    .hcount      (hcount),
    .vcount      (vcount),
    .h_blank     (h_blank),
    .v_blank     (v_blank),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .line_start  (line_start),
    .frame_start (frame_start),
    .mode_active (mode_active)
  );

  int checks = 0;
  int failures = 0;

  int k = 0;
  int pix = 0;
  bit m_mode = 1'b0;
  bit e_ce = 1'b0;
  bit e_ls = 1'b0;
  bit e_fs = 1'b0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int vt_total(input bit pal);
    return pal ? 312 : 262;
  endfunction

  function automatic int vt_act(input bit pal);
    return pal ? 288 : 240;
  endfunction

  function automatic bit pick(input bit want);
    int ln;
    ln = pix / HT;
    if (ln >= 20 && ln <= 90)
      return 1'($urandom_range(0, 1));
    return want;
  endfunction

  task automatic tick(input bit rst, input bit mp);
    int eh;
    int ev;
    int va;
    @(negedge clk);
    reset = rst;
    mode_pal = mp;
    @(posedge clk);
    if (rst) begin
      k = 0;
      pix = 0;
      m_mode = mp;
      e_ce = 0;
      e_ls = 0;
      e_fs = 0;
    end else begin
      k++;
      e_ce = (k % CE == 0);
      e_ls = 0;
      e_fs = 0;
      if (e_ce) begin
        pix++;
        if (pix == HT * vt_total(m_mode)) begin
          pix = 0;
          e_fs = 1;
          m_mode = mp;
        end
        e_ls = (pix % HT == 0);
      end
    end
    #1;
    eh = pix % HT;
    ev = pix / HT;
    va = vt_act(m_mode);
    check("ce_pix", ce_pix, e_ce);
    check("hcount", hcount, eh);
    check("vcount", vcount, ev);
    check("h_blank", h_blank, eh >= HA);
    check("v_blank", v_blank, ev >= va);
    check("h_sync", h_sync,
          eh >= HA + HFP && eh < HA + HFP + HSY);
    check("v_sync", v_sync,
          ev >= va + 3 && ev < va + 6);
    check("line_start", line_start, e_ls);
    check("frame_start", frame_start, e_fs);
    check("mode_active", mode_active, m_mode);
    check("inv_ls_ce", line_start & ~ce_pix, 0);
    check("inv_fs_ls", frame_start & ~line_start, 0);
    check("inv_hblank", h_blank, hcount >= 9'(HA));
  endtask

  initial begin
    int fs_n = 0;
    int ls_cnt = 0;
    int t_fs[3];
    int first_ce = -1;
    int hb_f1 = 0;
    int vmax = 0;
    int vs_first = -1;
    int vs_last = -1;
    int vb_first = -1;
    int mchg = 0;
    int rh;
    bit want = 0;
    bit prev_mode;
    bit found = 0;

    repeat (3) tick(1, 0);

    for (int c = 0; c < 60000 && fs_n < 3; c++) begin
      if (fs_n == 1 && vcount >= 9'd100)
        want = 1;
      prev_mode = mode_active;
      tick(0, pick(want));
      if (ce_pix && first_ce < 0)
        first_ce = k;
      if (mode_active != prev_mode) begin
        mchg++;
        check("mode_chg_on_fs", frame_start, 1);
      end
      if (fs_n == 0 && ce_pix && h_blank)
        hb_f1++;
      if (fs_n == 2 && v_sync) begin
        if (vs_first < 0)
          vs_first = int'(vcount);
        vs_last = int'(vcount);
      end
      if (fs_n == 2 && v_blank && vb_first < 0)
        vb_first = int'(vcount);
      if (line_start)
        ls_cnt++;
      if (frame_start) begin
        check("lines_per_frame", ls_cnt,
              fs_n < 2 ? 262 : 312);
        check("vmax", vmax, fs_n < 2 ? 261 : 311);
        t_fs[fs_n] = k;
        fs_n++;
        ls_cnt = 0;
        vmax = 0;
      end
      if (int'(vcount) > vmax)
        vmax = int'(vcount);
    end

    check("frame_timeout", fs_n, 3);
    check("first_ce", first_ce, CE);
    check("ntsc_period1", t_fs[0], HT * 262 * CE);
    check("ntsc_period2", t_fs[1] - t_fs[0],
          HT * 262 * CE);
    check("pal_period", t_fs[2] - t_fs[1],
          HT * 312 * CE);
    check("hblank_px", hb_f1, (HT - HA) * 262);
    check("mode_changes", mchg, 1);
    check("pal_vs_first", vs_first, 291);
    check("pal_vs_last", vs_last, 293);
    check("pal_vb_first", vb_first, 288);

    rh = $urandom_range(1, HT - 2);
    for (int c = 0; c < 40000 && !found; c++) begin
      tick(0, pick(1));
      found = (vcount == 9'd150) &&
              (hcount == 9'(rh));
    end
    check("reach_reset_pt", found, 1);

    tick(1, 0);
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    check("rst_strobes",
          {ce_pix, line_start, frame_start}, 0);
    check("rst_mode", mode_active, 0);

    first_ce = -1;
    for (int c = 0; c < 20; c++) begin
      tick(0, 0);
      if (ce_pix && first_ce < 0)
        first_ce = k;
    end
    check("rst_first_ce", first_ce, CE);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
